// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline stages and the pipeline sequencer.
// The requesting stages use the master side; the sequencer uses the slave side.
interface pipe_ctrl_if #(
    parameter int CNT_W  = 4,
    parameter int PERF_W = 16
);
    logic              id_stall_req;
    logic              ex_start;
    logic [CNT_W-1:0]  ex_cycles;
    logic              flush_req;
    logic [5:0]        stall;
    logic              flush;
    logic              busy;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_stall_req, ex_start, ex_cycles, flush_req,
        input  stall, flush, busy, stall_cycles
    );

    modport slave (
        input  id_stall_req, ex_start, ex_cycles, flush_req,
        output stall, flush, busy, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges ID/EX stall and flush requests into per-stage stall and flush
// controls for the five-stage core, and counts front-end stall cycles for debug.
module pipe_ctrl #(
    parameter int CNT_W  = 4,
    parameter int PERF_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic {RUN, EX_WAIT} state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, next_cnt;
    logic               flush_pend, next_flush_pend;
    logic [PERF_W-1:0]  stall_cycles;
    logic [5:0]         stall_c;
    logic               flush_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            cnt          <= '0;
            flush_pend   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            flush_pend <= next_flush_pend;
            if (stall_c[0] && (stall_cycles != {PERF_W{1'b1}}))
                stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    // Outputs are Mealy so a request stalls or flushes the pipe in the cycle it is raised.
    always_comb begin
        next_state      = state;
        next_cnt        = cnt;
        next_flush_pend = flush_pend;
        stall_c         = STALL_NONE;
        flush_c         = 1'b0;

        unique case (state)
            RUN: begin
                if (bus.flush_req || flush_pend) begin
                    flush_c         = 1'b1;
                    next_flush_pend = 1'b0;
                end else if (bus.ex_start && (bus.ex_cycles >= CNT_W'(2))) begin
                    stall_c    = STALL_EX;
                    next_state = EX_WAIT;
                    next_cnt   = bus.ex_cycles - CNT_W'(1);
                end else if (bus.ex_start) begin
                    stall_c = STALL_NONE;
                end else if (bus.id_stall_req) begin
                    stall_c = STALL_ID;
                end
            end

            EX_WAIT: begin
                stall_c  = STALL_EX;
                next_cnt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1))
                    next_state = RUN;
                // A flush raised while EX is held is replayed on the first RUN cycle.
                if (bus.flush_req)
                    next_flush_pend = 1'b1;
            end

            default: next_state = RUN;
        endcase

        if (!rst) begin
            stall_c = STALL_NONE;
            flush_c = 1'b0;
        end
    end

    assign bus.stall        = stall_c;
    assign bus.flush        = flush_c;
    assign bus.busy         = (state == EX_WAIT) && rst;
    assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, hand-written corner sequences,
// randomized traffic against a cycle-level reference model, and counter saturation.
module tb_pipe_ctrl;

    localparam int CNT_W  = 4;
    localparam int PERF_W = 16;
    localparam int CNT_MAX = (1 << PERF_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

    pipe_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: remaining held cycles of the current EX op, a pending flush flag,
    // and the stall-cycle count as a plain integer.
    int  m_rem  = 0;
    bit  m_pend = 1'b0;
    int  m_cnt  = 0;

    logic [5:0]        e_stall;
    logic              e_flush;
    logic              e_busy;
    logic [PERF_W-1:0] e_cnt;

    typedef struct {
        logic       id;
        logic       es;
        logic [3:0] ec;
        logic       fr;
        logic [5:0] stall;
        logic       flush;
        logic       busy;
    } vec_t;

    vec_t tbl[17];

    task automatic modelStep();
        int n;
        e_stall = 6'h00;
        e_flush = 1'b0;
        e_busy  = 1'b0;
        if (!rst) begin
            m_rem  = 0;
            m_pend = 1'b0;
            m_cnt  = 0;
            e_cnt  = '0;
            return;
        end
        e_cnt = PERF_W'(m_cnt);
        if (m_rem > 0) begin
            e_stall = 6'h0F;
            e_busy  = 1'b1;
            if (bus.flush_req) m_pend = 1'b1;
            m_rem--;
        end else if (bus.flush_req || m_pend) begin
            e_flush = 1'b1;
            m_pend  = 1'b0;
        end else if (bus.ex_start) begin
            n = (bus.ex_cycles == 0) ? 1 : int'(bus.ex_cycles);
            if (n >= 2) begin
                e_stall = 6'h0F;
                m_rem   = n - 1;
            end
        end else if (bus.id_stall_req) begin
            e_stall = 6'h07;
        end
        if (e_stall[0] && (m_cnt < CNT_MAX)) m_cnt++;
    endtask

    task automatic applyStimulus(input logic id, input logic es, input logic [3:0] ec,
                                 input logic fr);
        @(posedge clk);
        #1;
        bus.id_stall_req = id;
        bus.ex_start     = es;
        bus.ex_cycles    = ec;
        bus.flush_req    = fr;
        @(negedge clk);
        modelStep();
    endtask

    task automatic checkOutput(input string name, input logic [5:0] x_stall,
                               input logic x_flush, input logic x_busy,
                               input logic [PERF_W-1:0] x_cnt);
        vectors += 4;
        if (bus.stall !== x_stall) begin
            miscompares++;
            $display("[TB] FAIL %s stall: got %b expected %b", name, bus.stall, x_stall);
        end
        if (bus.flush !== x_flush) begin
            miscompares++;
            $display("[TB] FAIL %s flush: got %b expected %b", name, bus.flush, x_flush);
        end
        if (bus.busy !== x_busy) begin
            miscompares++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, bus.busy, x_busy);
        end
        if (bus.stall_cycles !== x_cnt) begin
            miscompares++;
            $display("[TB] FAIL %s stall_cycles: got %h expected %h", name, bus.stall_cycles, x_cnt);
        end
    endtask

    initial begin
        //          id  es  ec     fr  stall  flush busy
        tbl[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 6'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'd0, 1'b0, 6'h07, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'd4, 1'b0, 6'h0F, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'd0, 1'b0, 6'h0F, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 4'd0, 1'b0, 6'h0F, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 4'd9, 1'b0, 6'h0F, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 6'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'd1, 1'b0, 6'h00, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'd0, 1'b0, 6'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 4'd0, 1'b0, 6'h07, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 4'd3, 1'b1, 6'h00, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 4'd0, 1'b0, 6'h07, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'd3, 1'b0, 6'h0F, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'd0, 1'b1, 6'h0F, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 4'd0, 1'b0, 6'h0F, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 4'd0, 1'b0, 6'h00, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 4'd0, 1'b0, 6'h00, 1'b0, 1'b0};

        bus.id_stall_req = 1'b0;
        bus.ex_start     = 1'b0;
        bus.ex_cycles    = '0;
        bus.flush_req    = 1'b0;

        // Power-on reset, with a flush request present to show outputs stay quiet.
        @(negedge clk);
        bus.flush_req = 1'b1;
        #1;
        modelStep();
        checkOutput("por", 6'h00, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.flush_req = 1'b0;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].id, tbl[i].es, tbl[i].ec, tbl[i].fr);
            checkOutput($sformatf("vec%0d", i), tbl[i].stall, tbl[i].flush, tbl[i].busy, e_cnt);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("table_cnt", 6'h00, 1'b0, 1'b0, PERF_W'(10));

        // Reset in the middle of EX_WAIT (cnt=5) with a flush pending.
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b0);
        checkOutput("mid_start", e_stall, e_flush, e_busy, e_cnt);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("mid_flushreq", 6'h0F, 1'b0, 1'b1, e_cnt);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid_wait", 6'h0F, 1'b0, 1'b1, e_cnt);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.flush_req = 1'b1;
        @(negedge clk);
        modelStep();
        checkOutput("rst_hold", 6'h00, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.flush_req = 1'b0;
        @(negedge clk);
        modelStep();
        checkOutput("post_rst", 6'h00, 1'b0, 1'b0, '0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
            checkOutput($sformatf("rnd%0d", i), e_stall, e_flush, e_busy, e_cnt);
        end

        // Drive the counter into saturation with back-to-back ID stalls.
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 65540; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        checkOutput("sat_reach", 6'h07, 1'b0, 1'b0, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
        checkOutput("sat_ex", 6'h0F, 1'b0, 1'b0, 16'hFFFF);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        checkOutput("sat_hold", e_stall, e_flush, e_busy, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
